pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer_if.sv | 34 +++
 rtl/pll_lock_sequencer.sv | 156 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and consumer-side signals of the lock sequencer, bundled for port connection.
// The sequencer connects through the master modport.
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fault,
        output retry_count,
        output loss_count
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fault,
        input  retry_count,
        input  loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// releases the downstream reset, and retries or faults on lock timeout.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_sequencer_if.master  bus
);
    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             lock_s_q;
    logic             pll_rst_q;
    logic             sys_rst_n_q;
    logic             ready_q;
    logic             fault_q;
    logic [3:0]       retry_q;
    logic [7:0]       loss_q;
    logic [7:0]       loss_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Saturating next value of the lock-loss counter.
    always_comb begin
        loss_d = sat_inc8(loss_q);
    end

    // Lock synchronizer, sequencing FSM and registered outputs.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
        end else begin
            sync1_q  <= bus.pll_locked;
            lock_s_q <= sync1_q;
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        cnt_q <= '0;
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_q     <= S_RUN;
                            retry_q     <= 4'd0;
                            sys_rst_n_q <= 1'b1;
                            ready_q     <= 1'b1;
                        end else begin
                            state_q <= S_STABLE;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q <= '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_q   <= retry_q + 4'd1;
                            state_q   <= S_RESET_PLL;
                            pll_rst_q <= 1'b1;
                        end else begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_s_q) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        retry_q     <= 4'd0;
                        sys_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s_q || bus.relock_req) begin
                        state_q     <= S_RESET_PLL;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                        ready_q     <= 1'b0;
                        if (!lock_s_q) begin
                            loss_q <= loss_d;
                        end
                    end
                end
                S_FAULT: begin
                    if (bus.relock_req) begin
                        state_q   <= S_RESET_PLL;
                        cnt_q     <= '0;
                        retry_q   <= 4'd0;
                        fault_q   <= 1'b0;
                        pll_rst_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_RESET_PLL;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: stimulus pushes cycle-stamped expected output
// vectors into a scoreboard queue that a separate monitor drains and compares.
module tb_pll_lock_sequencer;
    localparam int RP = 4;
    localparam int TO = 32;
    localparam int ST = 8;
    localparam int MR = 2;

    logic refclk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    pll_lock_sequencer_if bus_if();

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (RP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (ST),
        .MAX_RETRIES        (MR)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus_if.master)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];

    logic [15:0] obs;
    assign obs = {bus_if.pll_rst, bus_if.sys_rst_n, bus_if.ready, bus_if.fault,
                  bus_if.retry_count, bus_if.loss_count};

    function automatic logic [15:0] ev(logic pr, logic sn, logic rd, logic ft, int rt, int ls);
        return {pr, sn, rd, ft, 4'(rt), 8'(ls)};
    endfunction

    task automatic push(int at, string tag, logic [15:0] v);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic go(int n);
        repeat (n) @(negedge refclk);
    endtask

    // Monitor: compare every expectation stamped with the current cycle.
    initial begin
        forever begin
            @(negedge refclk);
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].at <= cyc) begin
                    n_checks++;
                    if (sb_q[i].at < cyc) begin
                        n_fail++;
                        $display("FAIL %s: expectation for cycle %0d was not checked (now %0d)",
                                 sb_q[i].tag, sb_q[i].at, cyc);
                    end else if (obs !== sb_q[i].val) begin
                        n_fail++;
                        $display("FAIL %s @cycle %0d: got %h required %h (pll_rst,sys_rst_n,ready,fault,retry[4],loss[8])",
                                 sb_q[i].tag, cyc, obs, sb_q[i].val);
                    end
                    sb_q.delete(i);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int d;
        int el;
        rst = 1'b0;
        bus_if.pll_locked = 1'b0;
        bus_if.relock_req = 1'b0;

        // Reset values and first PLL reset pulse; relock pulse in WAIT_LOCK is ignored.
        go(2);
        push(cyc + 1, "reset_values", ev(1, 0, 0, 0, 0, 0));
        go(2);
        rst = 1'b1;
        t = cyc;
        push(t + 3, "pulse_hi", ev(1, 0, 0, 0, 0, 0));
        push(t + 4, "pulse_end", ev(0, 0, 0, 0, 0, 0));
        go(6);
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(3);
        bus_if.pll_locked = 1'b1;
        t = cyc;
        push(t + 9, "ready_early", ev(0, 0, 0, 0, 0, 0));
        push(t + 10, "ready_rise", ev(0, 1, 1, 0, 0, 0));
        go(12);

        // Relock request alone in RUN: loss count unchanged.
        t = cyc;
        push(t + 1, "relock_enter", ev(1, 0, 0, 0, 0, 0));
        push(t + 12, "relock_not_yet", ev(0, 0, 0, 0, 0, 0));
        push(t + 13, "relock_run", ev(0, 1, 1, 0, 0, 0));
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(15);

        // Relock request coincident with lock loss: one RESET_PLL entry, loss +1.
        d = cyc;
        push(d + 2, "coinc_prior", ev(0, 1, 1, 0, 0, 0));
        push(d + 3, "coinc_enter", ev(1, 0, 0, 0, 0, 1));
        push(d + 6, "coinc_pulse", ev(1, 0, 0, 0, 0, 1));
        push(d + 7, "coinc_pulse_end", ev(0, 0, 0, 0, 0, 1));
        push(d + 15, "coinc_run", ev(0, 1, 1, 0, 0, 1));
        bus_if.pll_locked = 1'b0;
        go(1);
        bus_if.pll_locked = 1'b1;
        go(1);
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(17);

        // One-cycle lock glitch at stable count 5 restarts the stable window.
        t = cyc;
        push(t + 1, "gl_enter", ev(1, 0, 0, 0, 0, 1));
        push(t + 12, "gl_wait", ev(0, 0, 0, 0, 0, 1));
        push(t + 13, "gl_no_early_run", ev(0, 0, 0, 0, 0, 1));
        push(t + 19, "gl_not_yet", ev(0, 0, 0, 0, 0, 1));
        push(t + 20, "gl_run", ev(0, 1, 1, 0, 0, 1));
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(6);
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(1);
        bus_if.pll_locked = 1'b0;
        go(1);
        bus_if.pll_locked = 1'b1;
        go(14);

        // Repeated lock losses in RUN: loss count saturates at 255.
        for (int k = 1; k <= 256; k++) begin
            d = cyc;
            el = (k + 1 > 255) ? 255 : k + 1;
            push(d + 2, $sformatf("loss_prerun_%0d", k), ev(0, 1, 1, 0, 0, (k > 255) ? 255 : k));
            push(d + 3, $sformatf("loss_drop_%0d", k), ev(1, 0, 0, 0, 0, el));
            push(d + 15, $sformatf("loss_rerun_%0d", k), ev(0, 1, 1, 0, 0, el));
            bus_if.pll_locked = 1'b0;
            go(1);
            bus_if.pll_locked = 1'b1;
            go(19);
        end

        // Lock never returns: three pulses with retry 0,1,2, then FAULT; relocks in
        // RESET_PLL and WAIT_LOCK are ignored.
        d = cyc;
        push(d + 3, "to_enter", ev(1, 0, 0, 0, 0, 255));
        push(d + 38, "to_wait0", ev(0, 0, 0, 0, 0, 255));
        push(d + 39, "to_retry1", ev(1, 0, 0, 0, 1, 255));
        push(d + 74, "to_wait1", ev(0, 0, 0, 0, 1, 255));
        push(d + 75, "to_retry2", ev(1, 0, 0, 0, 2, 255));
        push(d + 110, "to_wait2", ev(0, 0, 0, 0, 2, 255));
        push(d + 111, "to_fault", ev(0, 0, 0, 1, 2, 255));
        push(d + 150, "to_fault_hold", ev(0, 0, 0, 1, 2, 255));
        bus_if.pll_locked = 1'b0;
        go(4);
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(15);
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(139);
        t = cyc;
        push(t + 1, "fault_clear", ev(1, 0, 0, 0, 0, 255));
        push(t + 13, "fault_recover_run", ev(0, 1, 1, 0, 0, 255));
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        bus_if.pll_locked = 1'b1;
        go(15);

        // Reset asserted in STABLE: reset values next cycle, then a full pulse.
        t = cyc;
        push(t + 8, "stable_pre_rst", ev(0, 0, 0, 0, 0, 255));
        push(t + 9, "rst_in_stable", ev(1, 0, 0, 0, 0, 0));
        push(t + 13, "rst_pulse_hi", ev(1, 0, 0, 0, 0, 0));
        push(t + 14, "rst_pulse_end", ev(0, 0, 0, 0, 0, 0));
        push(t + 21, "rst_not_yet", ev(0, 0, 0, 0, 0, 0));
        push(t + 22, "rst_run", ev(0, 1, 1, 0, 0, 0));
        bus_if.relock_req = 1'b1;
        go(1);
        bus_if.relock_req = 1'b0;
        go(7);
        rst = 1'b0;
        go(2);
        rst = 1'b1;
        go(16);

        go(3);
        while (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never compared", sb_q[0].tag, sb_q[0].at);
            void'(sb_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
